// File: rtl/pwm_fade_ctrl_pkg.sv
// Shared definitions for the PWM fade controller: state encoding and default width.
package pwm_fade_ctrl_pkg;

   // Default width of the period counter and of every duty/step/dwell quantity.
   localparam int CNT_W_DEF = 8;

   // Fade controller states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } fade_state_t;

endpackage

// File: rtl/pwm_fade_ctrl_step.sv
// Fade step engine: latches the effective step and dwell at fade start, counts
// dwell periods, and computes the saturated next duty in both directions.
module pwm_fade_step
   import pwm_fade_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             pwm_clk,
   input  logic             rst_n,
   input  logic             load,       // fade accepted this cycle
   input  logic [CNT_W-1:0] step_in,    // raw step, 0 means 1
   input  logic [CNT_W-1:0] dwell_in,   // raw dwell, 0 means 1
   input  logic             active,     // controller is in UP or DOWN
   input  logic             tick,       // last cycle of a PWM period
   input  logic [CNT_W-1:0] duty,
   input  logic [CNT_W-1:0] ceil_val,   // upper bound for an up step
   input  logic [CNT_W-1:0] floor_val,  // lower bound for a down step
   output logic             update,     // apply a new duty on this edge
   output logic [CNT_W-1:0] duty_up,
   output logic [CNT_W-1:0] duty_dn
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] step_q;
   logic [CNT_W-1:0] dwell_q;
   logic [CNT_W-1:0] dwell_cnt;
   logic [CNT_W-1:0] step_eff;
   logic [CNT_W-1:0] dwell_eff;
   logic [CNT_W:0]   up_sum;
   logic [CNT_W-1:0] dn_diff;

   assign step_eff  = (step_in  == '0) ? ONE : step_in;
   assign dwell_eff = (dwell_in == '0) ? ONE : dwell_in;

   // The dwell counter would reach 0 on this tick: update duty now and reload.
   assign update = active & tick & (dwell_cnt <= ONE);

   // Latch the fade configuration on start, then count down dwell periods.
   always_ff @(posedge pwm_clk or negedge rst_n) begin
      if (!rst_n) begin
         step_q    <= '0;
         dwell_q   <= '0;
         dwell_cnt <= '0;
      end else if (load) begin
         step_q    <= step_eff;
         dwell_q   <= dwell_eff;
         dwell_cnt <= dwell_eff;
      end else if (active && tick) begin
         if (dwell_cnt <= ONE) begin
            dwell_cnt <= dwell_q;
         end else begin
            dwell_cnt <= dwell_cnt - ONE;
         end
      end
   end

   // Saturating arithmetic: one bit wider going up, clamped at 0 going down.
   always_comb begin
      up_sum  = {1'b0, duty} + {1'b0, step_q};
      duty_up = (up_sum > {1'b0, ceil_val}) ? ceil_val : up_sum[CNT_W-1:0];
      dn_diff = (duty >= step_q) ? (duty - step_q) : '0;
      duty_dn = (dn_diff < floor_val) ? floor_val : dn_diff;
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM generator with a fade controller that ramps the duty once to a target
// or breathes continuously between 0 and a peak.
module pwm_fade_ctrl
   import pwm_fade_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             pwm_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [CNT_W-1:0] target,
   input  logic [CNT_W-1:0] step,
   input  logic [CNT_W-1:0] dwell,
   output logic [CNT_W-1:0] duty,
   output logic             pwm_pin,
   output logic             period_tick,
   output logic             busy,
   output logic             done
);

   fade_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] target_q;
   logic             mode_q;
   logic [CNT_W-1:0] floor_val;
   logic             load;
   logic             update;
   logic [CNT_W-1:0] duty_up;
   logic [CNT_W-1:0] duty_dn;

   // Breathe mode always descends to 0; a single ramp down stops at the target.
   assign floor_val   = mode_q ? '0 : target_q;
   assign load        = (state == ST_IDLE) && start && !stop;
   assign period_tick = (cnt == '1);

   // Free-running period counter, wraps from all-ones to 0.
   always_ff @(posedge pwm_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Registered compare: pwm_pin lags cnt by one cycle.
   always_ff @(posedge pwm_clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_pin <= 1'b0;
      end else begin
         pwm_pin <= (cnt < duty);
      end
   end

   pwm_fade_step #(
      .CNT_W (CNT_W)
   ) u_step (
      .pwm_clk   (pwm_clk),
      .rst_n     (rst_n),
      .load      (load),
      .step_in   (step),
      .dwell_in  (dwell),
      .active    (busy),
      .tick      (period_tick),
      .duty      (duty),
      .ceil_val  (target_q),
      .floor_val (floor_val),
      .update    (update),
      .duty_up   (duty_up),
      .duty_dn   (duty_dn)
   );

   // Fade FSM: owns duty, latched target/mode, busy and the done pulse; stop
   // has priority over any start or duty update in the same cycle.
   always_ff @(posedge pwm_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         duty     <= '0;
         target_q <= '0;
         mode_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !stop) begin
                  target_q <= target;
                  mode_q   <= mode;
                  if (target > duty) begin
                     state <= ST_UP;
                     busy  <= 1'b1;
                  end else if (target < duty) begin
                     state <= ST_DOWN;
                     busy  <= 1'b1;
                  end else if (!mode) begin
                     done <= 1'b1;
                  end else if (target == '0) begin
                     state <= ST_UP;
                     busy  <= 1'b1;
                  end else begin
                     state <= ST_DOWN;
                     busy  <= 1'b1;
                  end
               end
            end
            ST_UP: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (update) begin
                  duty <= duty_up;
                  if (duty_up == target_q) begin
                     if (mode_q) begin
                        state <= ST_DOWN;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            ST_DOWN: begin
               if (stop) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (update) begin
                  duty <= duty_dn;
                  if (duty_dn == floor_val) begin
                     if (mode_q) begin
                        state <= ST_UP;
                     end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of the PWM period counter and all duty, step and dwell quantities.
REQ-002 pwm_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  single-cycle request to begin a fade; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in every state.
REQ-006 mode  input  1  0 = single ramp to target, 1 = continuous breathe between 0 and target.
REQ-007 target  input  CNT_W  final duty (single mode) or peak duty (breathe mode).
REQ-008 step  input  CNT_W  duty increment per update; 0 is treated as 1.
REQ-009 dwell  input  CNT_W  PWM periods between updates; 0 is treated as 1.
REQ-010 duty  output  CNT_W  current duty register.
REQ-011 pwm_pin  output  1  registered PWM output, (cnt < duty).
REQ-012 period_tick  output  1  high for the one cycle in which cnt == all-ones.
REQ-013 busy  output  1  high in UP or DOWN.
REQ-014 done  output  1  one-cycle pulse when a single-mode ramp completes.

Function
REQ-015 Period counter cnt SHALL be free-running, increment every cycle and wrap from 2^CNT_W-1 to 0; duty 0 gives constant low, duty 255 gives 255/256 high.
REQ-016 pwm_pin SHALL register (cnt < duty) every cycle, giving one cycle of latency from cnt.
REQ-017 FSM states SHALL be IDLE, UP and DOWN.
REQ-018 In IDLE with start=1 and stop=0, target, effective step, effective dwell and mode SHALL be latched, and the dwell counter SHALL be loaded with the effective dwell.
REQ-019 On that start, the next state SHALL be UP if latched target > duty and DOWN if target < duty.
REQ-020 On a single-mode start with target == duty, the block SHALL stay in IDLE, pulse done in the next cycle and never assert busy.
REQ-021 On a breathe-mode start with target == duty, the block SHALL enter DOWN; with target == 0 and duty == 0 it SHALL enter UP.
REQ-022 In UP or DOWN, the dwell counter SHALL decrement on each period_tick cycle.
REQ-023 When the dwell counter reaches 0 on a period_tick, duty SHALL update on that same edge, so the new value applies from cnt == 0, and the dwell counter SHALL reload.
REQ-024 In UP, duty SHALL become min(duty + step, target), computed one bit wider with no wrap.
REQ-025 In DOWN, duty SHALL become max(duty - step, floor), where floor is target in single mode and 0 in breathe mode, computed with no underflow.
REQ-026 Single mode: the edge on which duty reaches target SHALL move the FSM to IDLE and pulse done in the following cycle.
REQ-027 Breathe mode: on reaching target in UP the FSM SHALL go to DOWN; on reaching 0 in DOWN it SHALL go to UP; it never self-terminates.
REQ-028 Breathe mode with latched target == 0: duty SHALL stay 0 and busy SHALL stay 1 until stop.
REQ-029 stop=1 in UP or DOWN SHALL force IDLE on the next edge, hold duty, and not pulse done.
REQ-030 stop wins over start and over a coincident duty update in the same cycle.
REQ-031 start while busy SHALL be ignored, and input changes while busy SHALL have no effect.

Reset
REQ-032 rst_n low SHALL asynchronously set state=IDLE and cnt=0, with dwell counter, latched config and duty all 0.
REQ-033 rst_n low SHALL asynchronously drive pwm_pin, busy, done and period_tick to 0.
REQ-034 Reset mid-fade SHALL abandon the fade with no done pulse; the first edge after release behaves as IDLE.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE/UP/DOWN) and the CNT_W default.
REQ-036 Saturating step arithmetic plus the dwell counter SHALL be one sub-module, pwm_fade_step; cnt, compare and FSM stay in the top.

Verification
REQ-037 Single up: duty=0, start with target=100, step=30, dwell=1 -> duty 30, 60, 90, 100 at successive wraps; done pulses once, busy drops.
REQ-038 Single down: from duty=100, start with target=10, step=0 (treated as 1), dwell=2 -> duty decreases by 1 every 512 cycles and stops exactly at 10.
REQ-039 Breathe: target=200, step=100, dwell=1 -> duty 100, 200, 100, 0, 100, ... with no done pulse.
REQ-040 Stop and start in the same cycle mid-UP at duty=60 -> IDLE, duty holds 60, no done, start ignored.
REQ-041 rst_n pulsed low mid-ramp -> all outputs 0 immediately, without waiting for a clock edge.
REQ-042 Duty=255 -> pwm_pin high 255 of every 256 cycles; single-mode start with target equal to current duty -> done pulse only.
